// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, default tag prefix
// and the baud-select codes understood by the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [3:0] TAG_PREFIX_DEFAULT = 4'hA;

  typedef enum logic [1:0] {
    BAUD_SEL_0 = 2'd0,
    BAUD_SEL_1 = 2'd1,
    BAUD_SEL_2 = 2'd2,
    BAUD_SEL_3 = 2'd3
  } baud_sel_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte-stream bus: NUM_REQ parallel valid/ready lanes plus the grant vector.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);

  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   grant_o;

  modport master (
    output req_data_i,
    output req_valid_i,
    output req_last_i,
    input  req_ready_o,
    input  grant_o
  );

  modport slave (
    input  req_data_i,
    input  req_valid_i,
    input  req_last_i,
    output req_ready_o,
    output grant_o
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr_i+1 with wrap.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found;
  logic [IDX_W-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin scheduler feeding one UART transmitter, with optional
// per-burst tag byte, burst-length limit, buffer-full throttling and baud ownership.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter logic [3:0] TAG_PREFIX = TAG_PREFIX_DEFAULT
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  uart_tx_scheduler_if.slave        req_if,
  input  logic [1:0]                cfg_baudrate_select_i,
  input  logic                      cfg_tag_en_i,
  input  logic [7:0]                cfg_max_burst_i,
  output logic [7:0]                data_o,
  output logic                      data_write_o,
  input  logic                      data_buffer_full_i,
  output logic [1:0]                baudrate_select_o,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               tag_en_q, tag_en_d;
  logic [7:0]         max_burst_q, max_burst_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               write_q, write_d;
  logic [1:0]         baud_q, baud_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic               accept;
  logic [7:0]         cnt_inc;
  logic               last_hit;
  logic               lim_hit;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (req_if.req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      idx_q       <= '0;
      grant_q     <= '0;
      tag_en_q    <= 1'b0;
      max_burst_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      baud_q      <= BAUD_SEL_0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      grant_q     <= grant_d;
      tag_en_q    <= tag_en_d;
      max_burst_q <= max_burst_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      write_q     <= write_d;
      baud_q      <= baud_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    tag_en_d    = tag_en_q;
    max_burst_d = max_burst_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    write_d     = 1'b0;
    baud_d      = baud_q;
    req_ready   = '0;
    accept      = 1'b0;
    cnt_inc     = cnt_q + 8'd1;
    last_hit    = req_if.req_last_i[idx_q];
    lim_hit     = (max_burst_q != 8'd0) && (cnt_inc == max_burst_q);

    case (state_q)
      IDLE: begin
        // Baud only follows the config while no burst is in flight.
        baud_d = cfg_baudrate_select_i;
        if (|req_if.req_valid_i) begin
          grant_d     = arb_gnt;
          idx_d       = arb_idx;
          tag_en_d    = cfg_tag_en_i;
          max_burst_d = cfg_max_burst_i;
          cnt_d       = '0;
          state_d     = cfg_tag_en_i ? TAG : DATA;
        end
      end

      TAG: begin
        if (!data_buffer_full_i) begin
          data_d  = {TAG_PREFIX, 4'(idx_q)};
          write_d = 1'b1;
          state_d = DATA;
        end
      end

      DATA: begin
        req_ready = grant_q & {NUM_REQ{~data_buffer_full_i}};
        accept    = req_if.req_valid_i[idx_q] & ~data_buffer_full_i;
        if (accept) begin
          data_d  = req_if.req_data_i[{idx_q, 3'b000} +: 8];
          write_d = 1'b1;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_inc;
          if (last_hit || lim_hit) begin
            ptr_d   = idx_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign req_if.req_ready_o = req_ready;
  assign req_if.grant_o     = grant_q;
  assign data_o             = data_q;
  assign data_write_o       = write_q;
  assign baudrate_select_o  = baud_q;
  assign busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a packet-level round-robin model predicts the transmitted byte stream,
// a negedge monitor compares every data_write_o pulse and the handshake/baud rules.
module tb_uart_tx_scheduler;

  localparam int NR = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] cfg_baud;
  logic       cfg_tag;
  logic [7:0] cfg_max;
  logic       full;
  logic [7:0] data_o;
  logic       data_write_o;
  logic [1:0] baud_o;
  logic       busy_o;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NR)) req_if ();

  uart_tx_scheduler #(
    .NUM_REQ    (NR),
    .TAG_PREFIX (4'hA)
  ) dut (
    .clock_i               (clk),
    .reset_n_i             (reset_n),
    .req_if                (req_if.slave),
    .cfg_baudrate_select_i (cfg_baud),
    .cfg_tag_en_i          (cfg_tag),
    .cfg_max_burst_i       (cfg_max),
    .data_o                (data_o),
    .data_write_o          (data_write_o),
    .data_buffer_full_i    (full),
    .baudrate_select_o     (baud_o),
    .busy_o                (busy_o)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned hold_start = 0;
  logic [NR-1:0] first_grant;
  logic [7:0]  exp_q[$];
  int unsigned wr_cyc_q[$];
  ent_t        drv_q[NR][$];
  int          model_ptr = NR - 1;

  logic       prev_busy = 1'b0;
  logic       prev_full = 1'b0;
  logic       prev_rstn = 1'b0;
  logic [1:0] prev_cfg  = 2'd0;
  logic [1:0] prev_baud = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet-level reference: bursts go to the next non-empty requester after the last owner.
  task automatic model_round(input bit tag_en, input int maxb);
    ent_t m[NR][$];
    ent_t e;
    int   p, g, n;
    for (int k = 0; k < NR; k++) m[k] = drv_q[k];
    p = model_ptr;
    forever begin
      g = -1;
      for (int i = 1; i <= NR; i++) begin
        if (g < 0 && m[(p + i) % NR].size() > 0) g = (p + i) % NR;
      end
      if (g < 0) break;
      if (tag_en) exp_q.push_back({4'hA, 4'(g)});
      n = 0;
      do begin
        e = m[g].pop_front();
        exp_q.push_back(e.d);
        n++;
      end while (!e.l && !(maxb != 0 && n == maxb));
      p = g;
    end
    model_ptr = p;
  endtask

  task automatic add_pkt(input int k, input int len);
    ent_t e;
    for (int i = 0; i < len; i++) begin
      e.d = 8'($urandom);
      e.l = (i == len - 1);
      drv_q[k].push_back(e);
    end
  endtask

  task automatic add_bytes3(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drv_q[k].push_back({a, 1'b0});
    drv_q[k].push_back({b, 1'b0});
    drv_q[k].push_back({c, 1'b1});
  endtask

  task automatic drive_reqs(input int gap);
    logic [8*NR-1:0] d;
    logic [NR-1:0]   v, l;
    for (int k = 0; k < NR; k++) begin
      if (drv_q[k].size() > 0) begin
        v[k]         = !req_if.grant_o[k] || ($urandom_range(99) >= gap);
        d[8*k +: 8]  = drv_q[k][0].d;
        l[k]         = drv_q[k][0].l;
      end else begin
        v[k]         = 1'b0;
        d[8*k +: 8]  = 8'($urandom);
        l[k]         = 1'($urandom);
      end
    end
    req_if.req_data_i  = d;
    req_if.req_valid_i = v;
    req_if.req_last_i  = l;
  endtask

  task automatic flush_all();
    for (int k = 0; k < NR; k++) drv_q[k].delete();
    exp_q.delete();
  endtask

  task automatic run_round(input bit tag_en, input int maxb, input int gap, input int fpct,
                           input bit brand, input int hold_after, input int rst_after,
                           input int baud_at, input logic [1:0] baud_val);
    logic [NR-1:0] acc;
    bit hold_done = 1'b0;
    int hold_left = 0;
    bit rst_pend  = 1'b0;
    bit done      = 1'b0;
    bit empty;
    @(posedge clk);
    #1;
    model_round(tag_en, maxb);
    wr_cyc_q.delete();
    cfg_tag     = tag_en;
    cfg_max     = 8'(maxb);
    full        = 1'b0;
    first_grant = '0;
    drive_reqs(gap);
    start_cyc = cyc;
    for (int b = 0; b < 3000 && !done; b++) begin
      @(negedge clk);
      acc = req_if.req_valid_i & req_if.req_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (acc[k] && drv_q[k].size() > 0) void'(drv_q[k].pop_front());
      if (cyc == start_cyc + 1) first_grant = req_if.grant_o;
      if (rst_pend) begin
        chk("rst_grant", 32'(req_if.grant_o), 0);
        chk("rst_ready", 32'(req_if.req_ready_o), 0);
        chk("rst_write", 32'(data_write_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_baud", 32'(baud_o), 0);
        reset_n   = 1'b1;
        flush_all();
        model_ptr = NR - 1;
        done      = 1'b1;
      end else begin
        if (rst_after >= 0 && wr_cyc_q.size() >= rst_after) begin
          reset_n  = 1'b0;
          rst_pend = 1'b1;
        end
        if (baud_at >= 0 && wr_cyc_q.size() >= baud_at) cfg_baud = baud_val;
        else if (brand && $urandom_range(9) == 0) cfg_baud = 2'($urandom);
        if (hold_after >= 0 && !hold_done && wr_cyc_q.size() >= hold_after) begin
          hold_done  = 1'b1;
          hold_left  = 10;
          hold_start = cyc;
        end
        if (hold_left > 0) begin
          full = 1'b1;
          hold_left--;
        end else begin
          full = ($urandom_range(99) < fpct);
        end
        drive_reqs(gap);
        empty = 1'b1;
        for (int k = 0; k < NR; k++) if (drv_q[k].size() > 0) empty = 1'b0;
        if (empty && exp_q.size() == 0 && !busy_o) done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL round_timeout: got %0d bytes still expected, expected 0", exp_q.size());
      flush_all();
    end
    req_if.req_valid_i = '0;
    full = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n   = 1'b1;
    flush_all();
    model_ptr = NR - 1;
  endtask

  // Monitor: scoreboard pop per write pulse, plus handshake and baud-ownership rules.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_rstn) begin
        chk("baud_rule", 32'(baud_o), 32'(prev_busy ? prev_baud : prev_cfg));
        if (data_write_o) chk("write_after_full", 32'(prev_full), 0);
      end
      if (req_if.grant_o != '0)
        chk("ready_mask", 32'(req_if.req_ready_o & ~(req_if.grant_o & {NR{~full}})), 0);
      if (data_write_o) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_byte: got %02h, expected no write (cycle %0d)", data_o, cyc);
        end else begin
          chk("tx_byte", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      prev_busy = busy_o;
      prev_full = full;
      prev_rstn = reset_n;
      prev_cfg  = cfg_baud;
      prev_baud = baud_o;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int bubble_hits;
    bit resume_seen;
    reset_n            = 1'b0;
    cfg_baud           = 2'd0;
    cfg_tag            = 1'b0;
    cfg_max            = 8'd0;
    full               = 1'b0;
    req_if.req_data_i  = '0;
    req_if.req_valid_i = '0;
    req_if.req_last_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", 32'(req_if.grant_o), 0);
    chk("reset_ready", 32'(req_if.req_ready_o), 0);
    chk("reset_write", 32'(data_write_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_data", 32'(data_o), 0);
    chk("reset_baud", 32'(baud_o), 0);
    reset_n = 1'b1;

    // Single packet, tag off
    add_bytes3(2, 8'h11, 8'h22, 8'h33);
    run_round(1'b0, 0, 0, 0, 1'b0, -1, -1, -1, 2'd0);
    chk("t1_grant", 32'(first_grant), 32'(4'b0100));
    chk("t1_nwrites", 32'(wr_cyc_q.size()), 3);
    chk("t1_first_lat", wr_cyc_q[0] - start_cyc, 2);
    chk("t1_last_lat", wr_cyc_q[2] - start_cyc, 4);
    chk("t1_busy_after", 32'(busy_o), 0);

    // Round robin with tags
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
      add_pkt(3, 2);
    end
    run_round(1'b1, 0, 0, 0, 1'b0, -1, -1, -1, 2'd0);
    chk("t2_nwrites", 32'(wr_cyc_q.size()), 18);
    chk("t2_tag_lat", wr_cyc_q[0] - start_cyc, 2);
    chk("t2_data_lat", wr_cyc_q[1] - start_cyc, 3);
    chk("t2_grant", 32'(first_grant), 32'(4'b0001));

    // Burst limit
    add_pkt(1, 5);
    run_round(1'b0, 3, 0, 0, 1'b0, -1, -1, -1, 2'd0);
    chk("t3_nwrites", 32'(wr_cyc_q.size()), 5);
    chk("t3_bubble", wr_cyc_q[3] - wr_cyc_q[2], 2);
    add_pkt(1, 5);
    add_pkt(0, 4);
    run_round(1'b0, 3, 0, 0, 1'b0, -1, -1, -1, 2'd0);
    chk("t3b_nwrites", 32'(wr_cyc_q.size()), 9);

    // Backpressure hold of 10 cycles
    add_pkt(3, 8);
    run_round(1'b0, 0, 0, 0, 1'b0, 2, -1, -1, 2'd0);
    bubble_hits = 0;
    resume_seen = 1'b0;
    foreach (wr_cyc_q[i]) begin
      if (wr_cyc_q[i] > hold_start && wr_cyc_q[i] <= hold_start + 10) bubble_hits++;
      if (wr_cyc_q[i] == hold_start + 11) resume_seen = 1'b1;
    end
    chk("t4_writes_in_hold", 32'(bubble_hits), 0);
    chk("t4_resume", 32'(resume_seen), 1);
    chk("t4_nwrites", 32'(wr_cyc_q.size()), 8);

    // Baud change mid-burst
    cfg_baud = 2'd0;
    repeat (3) @(posedge clk);
    add_pkt(0, 6);
    run_round(1'b1, 0, 0, 0, 1'b0, -1, -1, 2, 2'd2);
    @(posedge clk);
    #1;
    chk("t5_baud_idle", 32'(baud_o), 2);

    // Reset mid-burst, then first priority back to requester 0
    for (int k = 0; k < NR; k++) add_pkt(k, 6);
    run_round(1'b0, 0, 0, 0, 1'b0, -1, 3, -1, 2'd0);
    for (int k = 0; k < NR; k++) add_pkt(k, 2);
    run_round(1'b0, 0, 0, 0, 1'b0, -1, -1, -1, 2'd0);
    chk("t6_grant", 32'(first_grant), 32'(4'b0001));

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      n0 = 0;
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(99) < 60) begin
          for (int p = 0; p <= int'($urandom_range(1)); p++) begin
            add_pkt(k, 1 + int'($urandom_range(5)));
            n0++;
          end
        end
      end
      if (n0 == 0) add_pkt(int'($urandom_range(NR - 1)), 3);
      case ($urandom_range(5))
        0: n0 = 0;
        1: n0 = 1;
        2: n0 = 2;
        3: n0 = 3;
        4: n0 = 4;
        default: n0 = 7;
      endcase
      run_round(1'($urandom), n0, 20, 20, 1'b1, -1, -1, -1, 2'd0);
    end

    chk("final_sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
